// File: rtl/accel_bus_scheduler_pkg.sv
// accel_bus_scheduler_pkg: shared FSM encoding, grant encodings, pointer indices and watchdog limit
package accel_bus_scheduler_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ACTIVE, S_RELEASE} state_t;
    localparam logic [1:0] GID_NONE = 2'b00;
    localparam logic [1:0] GID_FFT  = 2'b01;
    localparam logic [1:0] GID_FIR  = 2'b10;
    localparam logic [1:0] GID_IIR  = 2'b11;
    localparam logic [1:0] IDX_FFT  = 2'd0;
    localparam logic [1:0] IDX_FIR  = 2'd1;
    localparam logic [1:0] IDX_IIR  = 2'd2;
    localparam int         WD_LIMIT = 16;
endpackage

// File: rtl/accel_bus_scheduler_if.sv
// accel_bus_scheduler_if: accelerator request/FIFO status and data-bus grant signals
//   slave  : scheduler side (requests, FIFO flags, beats in; enables, grant_id, ram_addr out)
//   master : accelerator / bus controller side (mirror of slave)
interface accel_bus_scheduler_if #(parameter int ADDR_W = 10);
    logic              fft_req, fir_req, iir_req;
    logic              to_fft_full, to_fir_full, to_iir_full;
    logic              from_fft_empty, from_fir_empty, from_iir_empty;
    logic              ram_read_enable, ram_write_enable;
    logic              fft_enable, fir_enable, iir_enable;
    logic [1:0]        grant_id;
    logic [ADDR_W-1:0] ram_addr;
    modport slave (
        input  fft_req, fir_req, iir_req,
        input  to_fft_full, to_fir_full, to_iir_full,
        input  from_fft_empty, from_fir_empty, from_iir_empty,
        input  ram_read_enable, ram_write_enable,
        output fft_enable, fir_enable, iir_enable, grant_id, ram_addr
    );
    modport master (
        output fft_req, fir_req, iir_req,
        output to_fft_full, to_fir_full, to_iir_full,
        output from_fft_empty, from_fir_empty, from_iir_empty,
        output ram_read_enable, ram_write_enable,
        input  fft_enable, fir_enable, iir_enable, grant_id, ram_addr
    );
endinterface

// File: rtl/accel_bus_scheduler_rr_arbiter3.sv
// rr_arbiter3: combinational 3-way round-robin pick, search starts after last grantee
//   elig  : eligible vector (bit0 FFT, bit1 FIR, bit2 IIR)
//   last  : index of last grantee
//   valid : any candidate eligible
//   pick  : index of selected grantee
module rr_arbiter3 import accel_bus_scheduler_pkg::*; (
    input  logic [2:0] elig,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] pick
);
    logic [1:0] c1, c2;
    always_comb begin
        c1    = (last == IDX_IIR) ? IDX_FFT : last + 2'd1;
        c2    = (c1 == IDX_IIR) ? IDX_FFT : c1 + 2'd1;
        pick  = elig[c1] ? c1 : elig[c2] ? c2 : last;
        valid = |elig;
    end
endmodule

// File: rtl/accel_bus_scheduler.sv
// accel_bus_scheduler: round-robin data-bus scheduler for FFT/FIR/IIR accelerators
//   clk, reset (async active-low), addr_clr (sync pointer clear)
//   bus         : accel_bus_scheduler_if.slave (requests, FIFO flags, beats, grants, ram_addr)
//   busy        : FSM not in IDLE
//   timeout_err : one-cycle pulse on watchdog release (only with SCHED_TIMEOUT_EN defined)
module accel_bus_scheduler import accel_bus_scheduler_pkg::*; #(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   addr_clr,
    accel_bus_scheduler_if.slave   bus,
    output logic                   busy,
    output logic                   timeout_err
);
    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d, last_q, last_d, arb_pick;
    logic [2:0]        en_q, en_d, req, full, empty, elig;
    logic [7:0]        cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0] ptr_q [3];
    logic [ADDR_W-1:0] ptr_d [3];
    logic              arb_valid, active, beat, rel, wd_hit;

    assign req    = {bus.iir_req, bus.fir_req, bus.fft_req};
    assign full   = {bus.to_iir_full, bus.to_fir_full, bus.to_fft_full};
    assign empty  = {bus.from_iir_empty, bus.from_fir_empty, bus.from_fft_empty};
    // A full inbound FIFO with nothing to drain outbound means the accelerator is stuck
    assign elig   = req & ~(full & empty);
    assign active = state_q == S_ACTIVE;
    assign beat   = active && (bus.ram_read_enable || bus.ram_write_enable);
    assign cnt_inc = cnt_q + 8'(beat);
    assign rel    = active && (cnt_inc >= 8'(BURST_LEN) || !elig[gnt_q] || wd_hit);

    rr_arbiter3 u_arb (.elig(elig), .last(last_q), .valid(arb_valid), .pick(arb_pick));

`ifdef SCHED_TIMEOUT_EN
    logic [4:0] wd_q, wd_d;
    logic       to_q, to_d;
    assign wd_hit = active && !beat && wd_q == 5'(WD_LIMIT - 1);
    always_comb begin
        wd_d = (active && !beat && !rel) ? wd_q + 5'd1 : '0;
        to_d = wd_hit;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
    assign timeout_err = to_q;
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        en_d    = '0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: state_d = |req ? S_ARB : S_IDLE;
            S_ARB: begin
                state_d = arb_valid ? S_ACTIVE : S_IDLE;
                gnt_d   = arb_valid ? arb_pick : gnt_q;
                en_d    = arb_valid ? 3'b001 << arb_pick : 3'b000;
            end
            S_ACTIVE: begin
                cnt_d   = cnt_inc;
                state_d = rel ? S_RELEASE : S_ACTIVE;
                en_d    = rel ? 3'b000 : en_q;
            end
            default: begin
                cnt_d   = '0;
                last_d  = gnt_q;
                state_d = |req ? S_ARB : S_IDLE;
            end
        endcase
        if (beat) ptr_d[gnt_q] = ptr_q[gnt_q] + ADDR_W'(1);
        if (addr_clr) ptr_d = '{default: '0};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            gnt_q   <= IDX_FFT;
            last_q  <= IDX_IIR;
            en_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.fft_enable = en_q[0];
    assign bus.fir_enable = en_q[1];
    assign bus.iir_enable = en_q[2];
    assign bus.grant_id   = en_q[0] ? GID_FFT : en_q[1] ? GID_FIR : en_q[2] ? GID_IIR : GID_NONE;
    assign bus.ram_addr   = active ? ptr_q[gnt_q] : '0;
    assign busy           = state_q != S_IDLE;
endmodule
